// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control stage: registers the decoded control bundle and register indices into EX, inserts load-use bubbles, applies redirect flushes.
// Latency: one cycle ID->EX when nothing stalls; each load-use hazard costs LOAD_USE_STALL bubble cycles.
// Backpressure: ex_hold freezes the EX register and stalls IF/ID; hazards and WAIT stall IF/ID; a redirect flushes IF/ID.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   id_valid, id_<field>   decoder control bundle and register indices presented by ID
//   ex_redirect, ex_hold   EX-side redirect (taken branch/jump) and "cannot accept" hold
//   ex_valid, ex_<field>   registered bundle in the EX slot (all zero for a bubble)
//   id_stall, id_flush     combinational hold / clear requests for PC and IF/ID
//   bubble_cnt             saturating count of bubbles inserted since reset
module id_ex_ctrl_stage #(
    parameter int REG_AW         = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [1:0]        id_alu_src,
    input  logic [3:0]        id_alu_op,
    input  logic [1:0]        id_branch_flag,
    input  logic              id_jump_flag,
    input  logic              id_mem_sext,
    input  logic              id_pc_src,
    input  logic [3:0]        id_mem_read,
    input  logic [3:0]        id_mem_write,
    input  logic              id_alu_op2,
    input  logic              id_rb_select,
    input  logic [1:0]        id_mem_to_reg,
    input  logic              id_dbl_jump,
    input  logic              id_reg_write,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_redirect,
    input  logic              ex_hold,
    output logic              ex_valid,
    output logic [1:0]        ex_alu_src,
    output logic [3:0]        ex_alu_op,
    output logic [1:0]        ex_branch_flag,
    output logic              ex_jump_flag,
    output logic              ex_mem_sext,
    output logic              ex_pc_src,
    output logic [3:0]        ex_mem_read,
    output logic [3:0]        ex_mem_write,
    output logic              ex_alu_op2,
    output logic              ex_rb_select,
    output logic [1:0]        ex_mem_to_reg,
    output logic              ex_dbl_jump,
    output logic              ex_reg_write,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic              ex_rs2_used,
    output logic [REG_AW-1:0] ex_rd,
    output logic              id_stall,
    output logic              id_flush,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic [1:0]        alu_src;
        logic [3:0]        alu_op;
        logic [1:0]        branch_flag;
        logic              jump_flag;
        logic              mem_sext;
        logic              pc_src;
        logic [3:0]        mem_read;
        logic [3:0]        mem_write;
        logic              alu_op2;
        logic              rb_select;
        logic [1:0]        mem_to_reg;
        logic              dbl_jump;
        logic              reg_write;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              rs2_used;
        logic [REG_AW-1:0] rd;
    } ctrl_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Bubbles still owed after the first one; the hazard cycle itself is bubble #1.
    localparam logic [2:0]       WAIT_INIT = 3'(LOAD_USE_STALL - 1);
    localparam logic [2:0]       WAIT_ONE  = 3'd1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_t      id_bundle;
    ctrl_t      ex_q;
    state_t     state;
    logic [2:0] wait_cnt;
    logic       hazard;
    logic       wait_stall;

    always_comb begin
        id_bundle             = '0;
        id_bundle.alu_src     = id_alu_src;
        id_bundle.alu_op      = id_alu_op;
        id_bundle.branch_flag = id_branch_flag;
        id_bundle.jump_flag   = id_jump_flag;
        id_bundle.mem_sext    = id_mem_sext;
        id_bundle.pc_src      = id_pc_src;
        id_bundle.mem_read    = id_mem_read;
        id_bundle.mem_write   = id_mem_write;
        id_bundle.alu_op2     = id_alu_op2;
        id_bundle.rb_select   = id_rb_select;
        id_bundle.mem_to_reg  = id_mem_to_reg;
        id_bundle.dbl_jump    = id_dbl_jump;
        id_bundle.reg_write   = id_reg_write;
        id_bundle.rs1         = id_rs1;
        id_bundle.rs2         = id_rs2;
        id_bundle.rs2_used    = id_rs2_used;
        id_bundle.rd          = id_rd;
    end

    // A load sitting in EX whose destination is read by the instruction in ID.
    assign hazard = id_valid & ex_valid & ex_q.reg_write & (ex_q.mem_read != 4'd0)
                  & (ex_q.rd != '0)
                  & ((ex_q.rd == id_rs1) | (id_rs2_used & (ex_q.rd == id_rs2)));

    // Load-use bubbles (first or continuing) are only honoured when no redirect is flushing ID.
    assign wait_stall = ~ex_redirect & ((state == ST_WAIT) | ((state == ST_RUN) & hazard));

    // Gated by reset so the front end sees no stall/flush request while the stage is held in reset.
    assign id_stall = ~reset & (ex_hold | wait_stall);
    assign id_flush = ~reset & ~ex_hold & ex_redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q       <= '0;
            ex_valid   <= 1'b0;
            state      <= ST_RUN;
            wait_cnt   <= 3'd0;
            bubble_cnt <= '0;
        end else if (!ex_hold) begin
            if (ex_redirect) begin
                ex_q     <= '0;
                ex_valid <= 1'b0;
                state    <= ST_RUN;
                wait_cnt <= 3'd0;
                if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_ONE;
            end else if (state == ST_WAIT) begin
                ex_q     <= '0;
                ex_valid <= 1'b0;
                wait_cnt <= wait_cnt - WAIT_ONE;
                if (wait_cnt == WAIT_ONE) state <= ST_RUN;
                if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_ONE;
            end else if (hazard) begin
                ex_q     <= '0;
                ex_valid <= 1'b0;
                if (LOAD_USE_STALL > 1) begin
                    wait_cnt <= WAIT_INIT;
                    state    <= ST_WAIT;
                end
                if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_ONE;
            end else begin
                // An empty ID slot flows into EX as a bubble but is not a stall-inserted one.
                ex_valid <= id_valid;
                ex_q     <= id_valid ? id_bundle : '0;
            end
        end
    end

    assign ex_alu_src     = ex_q.alu_src;
    assign ex_alu_op      = ex_q.alu_op;
    assign ex_branch_flag = ex_q.branch_flag;
    assign ex_jump_flag   = ex_q.jump_flag;
    assign ex_mem_sext    = ex_q.mem_sext;
    assign ex_pc_src      = ex_q.pc_src;
    assign ex_mem_read    = ex_q.mem_read;
    assign ex_mem_write   = ex_q.mem_write;
    assign ex_alu_op2     = ex_q.alu_op2;
    assign ex_rb_select   = ex_q.rb_select;
    assign ex_mem_to_reg  = ex_q.mem_to_reg;
    assign ex_dbl_jump    = ex_q.dbl_jump;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_rs1         = ex_q.rs1;
    assign ex_rs2         = ex_q.rs2;
    assign ex_rs2_used    = ex_q.rs2_used;
    assign ex_rd          = ex_q.rd;

endmodule
